oam_dma_controller: RTL
=======================

Name: oam_dma_controller

Overview:
- Implements the Game Boy OAM DMA register at FF46h.
- Sits between the CPU bus and memory_controller.
- A CPU write of page P to FF46h copies 160 bytes, P00h–P9Fh, into OAM at FE00h–FE9Fh, one byte per transfer slot.
- Arbitrates the single downstream bus between the CPU and the DMA engine, and locks the CPU out of non-high memory during the transfer.

Parameters:
- CYCLES_PER_BYTE, 4: clocks per byte slot; minimum 2.
- NUM_BYTES, 160: bytes per transfer.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- A_cpu  in  16  CPU address
- Dw_cpu  in  8  CPU write data
- Dr_cpu  out  8  read data to CPU
- rd_cpu_n  in  1  CPU read strobe, active-low
- wr_cpu_n  in  1  CPU write strobe, active-low
- A_mem  out  16  address to memory_controller
- Dw_mem  out  8  write data to memory_controller
- Dr_mem  in  8  read data from memory_controller
- rd_mem_n  out  1  downstream read strobe, active-low
- wr_mem_n  out  1  downstream write strobe, active-low
- dma_active  out  1  high from START through the final WAIT

Behaviour:

Reset:
- state=IDLE, index=0, src_page=00h, dma_reg=00h, dma_active=0.
- Downstream outputs follow CPU pass-through.
- Reset asserted mid-transfer aborts immediately; no further downstream writes occur.

FF46h register:
- CPU write at A_cpu==FF46h with wr_cpu_n=0:
  - latches dma_reg=Dw_cpu and src_page;
  - src_page = Dw_cpu−20h when Dw_cpu≥E0h, else Dw_cpu;
  - is consumed here: rd_mem_n/wr_mem_n held 1 and not forwarded.
- A CPU read of FF46h returns dma_reg. This register is always accessible, including during DMA.

State machine, evaluated each clock:
- IDLE: on an FF46h write → START.
- START: one-clock setup; index=0, slot counter=0 → READ.
- READ: drive A_mem={src_page,index[7:0]}, rd_mem_n=0; capture Dr_mem into data_reg at the clock edge → WRITE.
- WRITE: drive A_mem=FE00h+index, Dw_mem=data_reg, wr_mem_n=0 → WAIT.
- WAIT: idle bus slots until the slot counter reaches CYCLES_PER_BYTE−1. Then:
  - if index==NUM_BYTES−1 → IDLE;
  - else index+1 → READ.
- The slot counter resets on entry to READ.
- Unstalled transfer: 1 + NUM_BYTES×CYCLES_PER_BYTE clocks, i.e. 641 at defaults.

Arbitration:
- In READ or WRITE, a CPU strobe with A_cpu≥FF00h (I/O, HRAM, IE; FF46h excluded) wins the bus. The CPU access passes through that clock.
- The DMA holds its state and retries next clock; the slot counter does not advance.
- Those stall clocks lengthen the transfer.

Lockout and pass-through:
- Lockout while dma_active: CPU accesses with A_cpu<FF00h are not forwarded (strobes held 1); reads return Dr_cpu=FFh and writes are dropped.
- Pass-through otherwise: A_mem=A_cpu, Dw_mem=Dw_cpu, strobes copied, Dr_cpu=Dr_mem.

Restart:
- An FF46h write while dma_active → START with the new src_page; index restarts at 0.
- The byte in flight is abandoned; no partial write occurs if the restart lands in READ.

Index width: 8 bits; never exceeds NUM_BYTES−1.

Optional Feature:
- Macro: OAM_DMA_BUS_LOCK_EN.
- Defined: CPU lockout of A_cpu<FF00h during DMA, as above.
- Undefined:
  - no lockout; all CPU accesses pass through;
  - any CPU strobe during READ/WRITE takes priority and stalls the DMA;
  - Dr_cpu always comes from Dr_mem (or dma_reg for FF46h).

Test Plan:
- Reset, write C1h to FF46h with C100h–C19Fh preloaded with the pattern i^5Ah → after 641 clocks, FE00h–FE9Fh hold i^5Ah; dma_active falls; exactly 160 downstream writes occur.
- Write FEh to FF46h → source reads come from DE00h–DE9Fh; reading FF46h returns FEh.
- During DMA (lock enabled), CPU reads C000h → Dr_cpu=FFh and no downstream read; CPU writes C000h → memory unchanged. CPU reads FF85h → correct HRAM data; the DMA stalls one clock and completes at 642 clocks.
- At index 50, write 80h to FF46h → the transfer restarts at index 0 from 8000h; OAM ends holding 8000h–809Fh; total duration counts from the restart.
- Assert reset at index 10 → dma_active=0 next clock; no further OAM writes; OAM bytes 10+ unchanged.
- Lock disabled: CPU reads C000h during DMA → real data returned; DMA completion is delayed by one clock per CPU access that hits a READ/WRITE slot.

Source files
------------

// File: rtl/oam_dma_controller_if.sv
// CPU-side and memory-side bus bundle for the FF46h OAM DMA controller.
interface oam_dma_controller_if;
  logic [15:0] A_cpu;
  logic [7:0]  Dw_cpu;
  logic [7:0]  Dr_cpu;
  logic        rd_cpu_n;
  logic        wr_cpu_n;
  logic [15:0] A_mem;
  logic [7:0]  Dw_mem;
  logic [7:0]  Dr_mem;
  logic        rd_mem_n;
  logic        wr_mem_n;

  modport slave (
    input  A_cpu, Dw_cpu, rd_cpu_n, wr_cpu_n, Dr_mem,
    output Dr_cpu, A_mem, Dw_mem, rd_mem_n, wr_mem_n
  );

  modport master (
    output A_cpu, Dw_cpu, rd_cpu_n, wr_cpu_n, Dr_mem,
    input  Dr_cpu, A_mem, Dw_mem, rd_mem_n, wr_mem_n
  );
endinterface

// File: rtl/oam_dma_controller.sv
// Game Boy OAM DMA (FF46h): copies NUM_BYTES from page P into FE00h and arbitrates the bus.
// Define OAM_DMA_BUS_LOCK_EN to lock the CPU out of A_cpu<FF00h while DMA is active.
module oam_dma_controller #(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned NUM_BYTES       = 160
) (
  input  logic                 clock,
  input  logic                 reset,
  oam_dma_controller_if.slave  bus,
  output logic                 dma_active
);

  localparam int unsigned SW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    LAST_INDEX = 8'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, START, READ, WRITE, WAIT} state_t;

  state_t        state;
  logic [7:0]    index;
  logic [7:0]    src_page;
  logic [7:0]    dma_reg;
  logic [7:0]    data_reg;
  logic [SW-1:0] slot;

  logic cpu_strobe, is_reg, reg_write, dma_bus, cpu_prio, locked, stall, forward;

  assign cpu_strobe = !bus.rd_cpu_n || !bus.wr_cpu_n;
  assign is_reg     = (bus.A_cpu == 16'hFF46);
  assign reg_write  = is_reg && !bus.wr_cpu_n;
  assign dma_bus    = (state == READ) || (state == WRITE);

`ifdef OAM_DMA_BUS_LOCK_EN
  logic high;
  assign high     = (bus.A_cpu >= 16'hFF00);
  assign cpu_prio = cpu_strobe && high && !is_reg;
  assign locked   = dma_active && !high;
`else
  assign cpu_prio = cpu_strobe && !is_reg;
  assign locked   = 1'b0;
`endif

  assign stall   = dma_bus && cpu_prio;
  assign forward = !is_reg && !locked;

  always_comb begin
    bus.A_mem    = bus.A_cpu;
    bus.Dw_mem   = bus.Dw_cpu;
    bus.rd_mem_n = forward ? bus.rd_cpu_n : 1'b1;
    bus.wr_mem_n = forward ? bus.wr_cpu_n : 1'b1;
    // A winning CPU access keeps the bus; the DMA slot simply repeats next clock.
    if (dma_bus && !stall) begin
      if (state == READ) begin
        bus.A_mem    = {src_page, index};
        bus.rd_mem_n = 1'b0;
        bus.wr_mem_n = 1'b1;
      end else begin
        bus.A_mem    = 16'hFE00 + {8'h00, index};
        bus.Dw_mem   = data_reg;
        bus.rd_mem_n = 1'b1;
        bus.wr_mem_n = 1'b0;
      end
    end
  end

  always_comb begin
    if (is_reg)      bus.Dr_cpu = dma_reg;
    else if (locked) bus.Dr_cpu = 8'hFF;
    else             bus.Dr_cpu = bus.Dr_mem;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      src_page   <= '0;
      dma_reg    <= '0;
      data_reg   <= '0;
      slot       <= '0;
      dma_active <= 1'b0;
    end else if (reg_write) begin
      dma_reg    <= bus.Dw_cpu;
      src_page   <= (bus.Dw_cpu >= 8'hE0) ? bus.Dw_cpu - 8'h20 : bus.Dw_cpu;
      state      <= START;
      dma_active <= 1'b1;
    end else begin
      case (state)
        IDLE: ;
        START: begin
          index <= '0;
          slot  <= '0;
          state <= READ;
        end
        READ: if (!stall) begin
          data_reg <= bus.Dr_mem;
          slot     <= slot + 1'b1;
          state    <= WRITE;
        end
        WRITE, WAIT: if (!stall) begin
          if (slot == SLOT_LAST) begin
            slot <= '0;
            if (index == LAST_INDEX) begin
              state      <= IDLE;
              dma_active <= 1'b0;
            end else begin
              index <= index + 1'b1;
              state <= READ;
            end
          end else begin
            slot  <= slot + 1'b1;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
